hsi_tx_coder: RTL and testbench

//  Byte serializer and Manchester line coder for the HSI transmit path. Takes each

---
 rtl/hsi_tx_coder_if.sv | 12 +
 rtl/hsi_tx_coder.sv | 132 +++++++++++++
 tb/tb_hsi_tx_coder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hsi_tx_coder_if.sv
// Byte/handshake bundle between the command-word controller and the HSI Manchester coder.
interface hsi_tx_coder_if;
  logic [7:0] d;
  logic       d_rdy;
  logic       msg_end;
  logic       busy;
  logic       line;
  logic       ovr;

  modport master (output d, d_rdy, msg_end, input busy, line, ovr);
  modport slave  (input d, d_rdy, msg_end, output busy, line, ovr);
endinterface

// File: rtl/hsi_tx_coder.sv
// HSI transmit byte serializer: frames start + 8 data (MSB first) + odd parity and
// Manchester-codes it onto line; msg_end inserts an idle gap with busy held high.
module hsi_tx_coder #(
  parameter int CLK_DIV  = 4,
  parameter int GAP_BITS = 4
) (
  input  logic           clk,
  input  logic           n_rst,
  hsi_tx_coder_if.slave  bus
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int GAP_CYC = GAP_BITS * 2 * CLK_DIV;
  localparam int GAP_W   = $clog2(GAP_CYC);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [4:0]       HB_LAST  = 5'd19;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       hb_q, hb_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [9:0]       frame_q, frame_d;
  logic             gap_pend_q, gap_pend_d;
  logic             busy_q, busy_d;
  logic             line_q, line_d;
  logic             ovr_q, ovr_d;

  // Line level for half-bit h: the frame bit in the first half, its complement in the second.
  function automatic logic half_val(input logic [9:0] f, input logic [4:0] h);
    logic [3:0] idx;
    idx = 4'd9 - {1'b0, h[4:1]};
    return f[idx] ^ h[0];
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    div_d      = div_q;
    hb_d       = hb_q;
    gap_d      = gap_q;
    frame_d    = frame_q;
    busy_d     = busy_q;
    line_d     = line_q;
    gap_pend_d = gap_pend_q | bus.msg_end;
    ovr_d      = bus.d_rdy & busy_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        line_d = 1'b0;
        if (gap_pend_q) begin
          state_d    = GAP;
          busy_d     = 1'b1;
          gap_d      = '0;
          gap_pend_d = bus.msg_end;  // a msg_end arriving now or during the gap re-arms
        end else if (bus.d_rdy) begin
          state_d = SHIFT;
          busy_d  = 1'b1;
          line_d  = 1'b1;            // first half of the start bit
          frame_d = {1'b1, bus.d, ~^bus.d};
          div_d   = '0;
          hb_d    = '0;
        end
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (hb_q == HB_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            line_d  = 1'b0;
          end else begin
            hb_d   = hb_q + 5'd1;
            line_d = half_val(frame_q, hb_q + 5'd1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        line_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      hb_q       <= '0;
      gap_q      <= '0;
      frame_q    <= '0;
      gap_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      line_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      hb_q       <= hb_d;
      gap_q      <= gap_d;
      frame_q    <= frame_d;
      gap_pend_q <= gap_pend_d;
      busy_q     <= busy_d;
      line_q     <= line_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.line = line_q;
  assign bus.ovr  = ovr_q;

endmodule

// File: tb/tb_hsi_tx_coder.sv
// Directed + randomized bench for hsi_tx_coder; line levels come from a per-cycle frame model.
module tb_hsi_tx_coder;

  localparam int CLK_DIV   = 4;
  localparam int GAP_BITS  = 4;
  localparam int FRAME_CYC = 20 * CLK_DIV;
  localparam int GAP_CYC   = GAP_BITS * 2 * CLK_DIV;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rises[$];
  logic busy_prev = 1'b0;

  hsi_tx_coder_if bus();

  hsi_tx_coder #(.CLK_DIV(CLK_DIV), .GAP_BITS(GAP_BITS)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Record the cycle number of every busy rising edge.
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    busy_prev <= bus.busy;
    if (bus.busy && !busy_prev) rises.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: frame bits are start=1, d MSB first, then a parity bit making the ones count odd.
  // Each bit spans 2*CLK_DIV cycles: its value for the first half, the inverse for the second.
  function automatic logic exp_line(input logic [7:0] b, input int k);
    int bits[10];
    int ones = 0;
    int bi;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    bits[0] = 1;
    for (int i = 0; i < 8; i++) bits[i+1] = int'(b[7-i]);
    bits[9] = (ones % 2 == 0) ? 1 : 0;
    bi = bits[k / (2 * CLK_DIV)];
    if ((k % (2 * CLK_DIV)) < CLK_DIV) return (bi != 0);
    else return (bi == 0);
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", bus.busy, 0);
  endtask

  // Called on the first negedge with busy expected high; returns on the negedge after the frame.
  task automatic check_frame(input logic [7:0] b, input logic [7:0] nxt, input int hold,
                             input int msg_at, output int oc);
    oc = 0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      if (k == 0) bus.d = nxt;
      bus.d_rdy   = (k < hold);
      bus.msg_end = (k == msg_at);
      check($sformatf("busy %02h k%0d", b, k), bus.busy, 1);
      check($sformatf("line %02h k%0d", b, k), bus.line, exp_line(b, k));
      oc += int'(bus.ovr);
      @(negedge clk);
    end
    bus.msg_end = 1'b0;
    check("frame_end_busy", bus.busy, 0);
    check("frame_end_line", bus.line, 0);
  endtask

  task automatic check_gap();
    for (int k = 0; k < GAP_CYC; k++) begin
      check($sformatf("gap_busy k%0d", k), bus.busy, 1);
      check($sformatf("gap_line k%0d", k), bus.line, 0);
      @(negedge clk);
    end
    check("gap_end_busy", bus.busy, 0);
  endtask

  task automatic send(input logic [7:0] b, input int hold, input int msg_at, output int oc);
    wait_idle();
    bus.d     = b;
    bus.d_rdy = 1'b1;
    @(negedge clk);
    check_frame(b, b, hold, msg_at, oc);
  endtask

  initial begin
    int         oc;
    int         hold;
    logic [7:0] b1, b2;

    bus.d = '0; bus.d_rdy = 1'b0; bus.msg_end = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_line", bus.line, 0);
    check("rst_ovr",  bus.ovr,  0);
    n_rst = 1'b1;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);

    // 1: 0xA5, single-cycle d_rdy, no overrun
    send(8'hA5, 0, -1, oc);
    check("t1_ovr", oc, 0);

    // 2: back-to-back 0x01 then 0x00 with d_rdy held high
    wait_idle();
    rises.delete();
    bus.d = 8'h01; bus.d_rdy = 1'b1;
    @(negedge clk);
    check_frame(8'h01, 8'h00, 1000, -1, oc);
    @(negedge clk);
    check_frame(8'h00, 8'h00, 0, -1, oc);
    check("t2_rise_count", rises.size(), 2);
    if (rises.size() >= 2) check("t2_rise_spacing", rises[1] - rises[0], FRAME_CYC + 1);

    // 3: msg_end mid-byte -> byte intact, one idle cycle, then the gap
    send(8'($urandom), 0, 10, oc);
    @(negedge clk);
    check_gap();

    // 4: d_rdy with msg_end in IDLE; held d_rdy waits out the gap
    wait_idle();
    b1 = 8'($urandom); b2 = 8'($urandom);
    bus.d = b1; bus.d_rdy = 1'b1; bus.msg_end = 1'b1;
    @(negedge clk);
    check_frame(b1, b2, 1000, -1, oc);
    @(negedge clk);
    check_gap();
    @(negedge clk);
    check_frame(b2, b2, 0, -1, oc);

    // 5: d_rdy held three extra cycles -> three overrun pulses, frame unchanged
    send(8'($urandom), 3, -1, oc);
    check("t5_ovr", oc, 3);

    // 6: reset at half-bit 7 aborts at once; next byte goes out whole
    wait_idle();
    b1 = 8'($urandom);
    bus.d = b1; bus.d_rdy = 1'b1;
    @(negedge clk);
    bus.d_rdy = 1'b0;
    for (int k = 0; k < 7 * CLK_DIV; k++) begin
      check($sformatf("t6_line k%0d", k), bus.line, exp_line(b1, k));
      @(negedge clk);
    end
    n_rst = 1'b0;
    #1;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_line", bus.line, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("t6_post_busy", bus.busy, 0);
    check("t6_post_line", bus.line, 0);
    send(8'($urandom), 0, -1, oc);

    // Random bytes with random overrun lengths
    for (int n = 0; n < 8; n++) begin
      hold = int'($urandom_range(0, 2));
      send(8'($urandom), hold, -1, oc);
      check($sformatf("rand_ovr %0d", n), oc, hold);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
